// File: rtl/tt_sweep_pkg.sv
// Shared definitions for the truth-table sweep controller: FSM state encoding,
// row geometry and a helper that maps a row index onto its code bit position.
package tt_sweep_pkg;

    localparam int unsigned ROWS  = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Row 000 lands in the MSB of the code, row 111 in the LSB.
    function automatic logic [IDX_W-1:0] code_pos(input logic [IDX_W-1:0] row);
        return IDX_W'(ROWS - 1) - row;
    endfunction

endpackage

// File: rtl/tt_sweep_ctrl_settle_timer.sv
// settle_timer: loadable down-counter that measures how long a row is held.
//   clk, rst_n : clock, async active-low reset
//   load       : preload the counter for a fresh settle window
//   en         : count while asserted
//   expire     : high on the last cycle of the window (while en is high)
module settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    // A programmed value of 0 behaves as 1.
    localparam int unsigned EFF_CYCLES = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(EFF_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    // Counter register: preload on load, otherwise decrement toward zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= LOAD_VAL;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl: sweeps all 8 input rows of a 3-input gate, samples its output
// after a settle window per row, and compares the measured code with an
// expected code.
//   start/abort : begin (from IDLE) / cancel (APPLY or SAMPLE) a sweep
//   expected    : expected truth-table code, captured at start
//   dut_out     : gate-under-test output
//   in1/in2/in3 : gate inputs, {in1,in2,in3} = row index
//   busy/done   : sweep in progress / one-cycle completion pulse
//   result, match, mismatch : measured code, equality flag, bitwise difference
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [ROWS-1:0] expected,
    input  logic            dut_out,
    output logic            in1,
    output logic            in2,
    output logic            in3,
    output logic            busy,
    output logic            done,
    output logic [ROWS-1:0] result,
    output logic            match,
    output logic [ROWS-1:0] mismatch
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [ROWS-1:0]  exp_q, exp_d;
    logic [ROWS-1:0]  result_d;
    logic [ROWS-1:0]  mismatch_d;
    logic             match_d;
    logic             busy_d;
    logic             done_d;
    logic             tmr_load;
    logic             tmr_en;
    logic             tmr_expire;

    settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmr_load),
        .en     (tmr_en),
        .expire (tmr_expire)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            row_q    <= '0;
            idx_q    <= '0;
            exp_q    <= '0;
            result   <= '0;
            match    <= 1'b0;
            mismatch <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            idx_q    <= idx_d;
            exp_q    <= exp_d;
            result   <= result_d;
            match    <= match_d;
            mismatch <= mismatch_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    assign {in1, in2, in3} = idx_q;

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        idx_d      = idx_q;
        exp_d      = exp_q;
        result_d   = result;
        match_d    = match;
        mismatch_d = mismatch;
        busy_d     = busy;
        done_d     = 1'b0;
        tmr_load   = 1'b0;
        tmr_en     = 1'b0;

        case (state_q)
            IDLE: begin
                // abort beats start when both arrive together.
                if (start && !abort) begin
                    state_d    = APPLY;
                    row_d      = '0;
                    idx_d      = '0;
                    exp_d      = expected;
                    result_d   = '0;
                    match_d    = 1'b0;
                    mismatch_d = '0;
                    busy_d     = 1'b1;
                    tmr_load   = 1'b1;
                end
            end

            APPLY: begin
                if (abort) begin
                    state_d    = IDLE;
                    idx_d      = '0;
                    busy_d     = 1'b0;
                    match_d    = 1'b0;
                    mismatch_d = '0;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_expire) begin
                        state_d = SAMPLE;
                    end
                end
            end

            SAMPLE: begin
                if (abort) begin
                    state_d    = IDLE;
                    idx_d      = '0;
                    busy_d     = 1'b0;
                    match_d    = 1'b0;
                    mismatch_d = '0;
                end else begin
                    result_d[code_pos(row_q)] = dut_out;
                    if (row_q == IDX_W'(ROWS - 1)) begin
                        // Compare against the code including the bit captured now,
                        // so match/mismatch appear together with done.
                        state_d    = DONE;
                        idx_d      = '0;
                        done_d     = 1'b1;
                        match_d    = (result_d == exp_q);
                        mismatch_d = result_d ^ exp_q;
                    end else begin
                        state_d  = APPLY;
                        row_d    = row_q + IDX_W'(1);
                        idx_d    = row_q + IDX_W'(1);
                        tmr_load = 1'b1;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: two instances (settle 4 and settle 1) each driving a
// modelled 3-input gate with optional 3-cycle propagation delay.
module tb_tt_sweep_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start, abort, start1, abort1;
    logic [7:0] expected;
    logic       dut_out, dut_out1;
    logic       in1, in2, in3, busy, done, match;
    logic [7:0] result, mismatch;
    logic       in1_1, in2_1, in3_1, busy1, done1, match1;
    logic [7:0] result1, mismatch1;

    logic [7:0] gate_code;
    logic       delay_on;
    logic [2:0] h0, h1, h2, g0, g1, g2;

    int n_chk;
    int n_fail;

    tt_sweep_ctrl #(.SETTLE_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .expected(expected), .dut_out(dut_out),
        .in1(in1), .in2(in2), .in3(in3), .busy(busy), .done(done),
        .result(result), .match(match), .mismatch(mismatch)
    );

    tt_sweep_ctrl #(.SETTLE_CYCLES(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .expected(expected), .dut_out(dut_out1),
        .in1(in1_1), .in2(in2_1), .in3(in3_1), .busy(busy1), .done(done1),
        .result(result1), .match(match1), .mismatch(mismatch1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate model: output for row idx is code bit 7-idx.
    function automatic logic gate_bit(input logic [7:0] code, input logic [2:0] idx);
        return code[3'd7 - idx];
    endfunction

    // Input history: hN holds the inputs seen N+1 cycles ago.
    always @(posedge clk) begin
        h0 <= {in1, in2, in3};
        h1 <= h0;
        h2 <= h1;
        g0 <= {in1_1, in2_1, in3_1};
        g1 <= g0;
        g2 <= g1;
    end

    assign dut_out  = gate_bit(gate_code, delay_on ? h2 : {in1, in2, in3});
    assign dut_out1 = gate_bit(gate_code, delay_on ? g2 : {in1_1, in2_1, in3_1});

    // Reference: row r is held for s+1 cycles starting at cycle r*(s+1) after
    // the start edge and sampled at the end of its last cycle; a gate with d
    // cycles of delay reports the row applied d cycles earlier (000 before start).
    function automatic logic [7:0] predict(input int s, input int d, input logic [7:0] g);
        logic [7:0] r;
        int         m;
        int         src;
        r = '0;
        for (int row = 0; row < 8; row++) begin
            m   = row * (s + 1) + s - d;
            src = (m < 0) ? 0 : m / (s + 1);
            r[7 - row] = g[7 - src];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Full sweep on the settle-4 instance with per-cycle input/busy/done checks.
    task automatic sweep4(input logic [7:0] exp_code, input logic [7:0] want,
                          input bit poke_start, input bit abort_done, input string tag);
        @(negedge clk);
        expected = exp_code;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        expected = ~exp_code;   // must have no effect after capture
        for (int j = 0; j <= 40; j++) begin
            chk({tag, ".idx"},  32'({in1, in2, in3}), (j < 40) ? 32'(j / 5) : 32'd0);
            chk({tag, ".busy"}, 32'(busy), 32'd1);
            chk({tag, ".done"}, 32'(done), (j == 40) ? 32'd1 : 32'd0);
            if (j == 40) begin
                chk({tag, ".result"},   32'(result),   32'(want));
                chk({tag, ".match"},    32'(match),    (want == exp_code) ? 32'd1 : 32'd0);
                chk({tag, ".mismatch"}, 32'(mismatch), 32'(want ^ exp_code));
            end
            if (poke_start && j == 12) start = 1'b1;
            if (poke_start && j == 14) start = 1'b0;
            if (abort_done && j == 40) abort = 1'b1;
            @(negedge clk);
        end
        abort = 1'b0;
        chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
        chk({tag, ".idle_done"}, 32'(done), 32'd0);
        chk({tag, ".hold_res"},  32'(result),   32'(want));
        chk({tag, ".hold_mm"},   32'(mismatch), 32'(want ^ exp_code));
    endtask

    initial begin
        logic [7:0] g, e;
        bit         saw_done;

        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        start1    = 1'b0;
        abort1    = 1'b0;
        expected  = 8'h00;
        gate_code = 8'h89;
        delay_on  = 1'b0;

        // Reset state
        #3;
        chk("rst.idx",  32'({in1, in2, in3}), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.res",  32'(result), 32'd0);
        chk("rst.match", 32'(match), 32'd0);
        chk("rst.mm",   32'(mismatch), 32'd0);
        chk("rst.busy1", 32'(busy1), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Basic sweeps
        sweep4(8'h89, 8'h89, 1'b0, 1'b0, "pass");
        sweep4(8'h91, 8'h89, 1'b0, 1'b0, "diff");
        repeat (5) @(negedge clk);
        chk("hold.res",   32'(result),   32'h89);
        chk("hold.match", 32'(match),    32'd0);
        chk("hold.mm",    32'(mismatch), 32'h18);

        // Slow gate: long settle hides the delay, short settle samples stale rows
        delay_on = 1'b1;
        repeat (4) @(negedge clk);
        sweep4(8'h89, predict(4, 3, 8'h89), 1'b0, 1'b0, "dly4");
        @(negedge clk);
        start1   = 1'b1;
        expected = 8'h89;
        @(negedge clk);
        start1 = 1'b0;
        for (int j = 0; j <= 16; j++) begin
            chk("dly1.idx",  32'({in1_1, in2_1, in3_1}), (j < 16) ? 32'(j / 2) : 32'd0);
            chk("dly1.done", 32'(done1), (j == 16) ? 32'd1 : 32'd0);
            if (j == 16) begin
                chk("dly1.result", 32'(result1), 32'(predict(1, 3, 8'h89)));
                chk("dly1.match",  32'(match1), (predict(1, 3, 8'h89) == 8'h89) ? 32'd1 : 32'd0);
            end
            @(negedge clk);
        end
        delay_on = 1'b0;
        repeat (4) @(negedge clk);

        // Abort during row 3 APPLY
        expected = 8'h89;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);
        chk("abt.row3", 32'({in1, in2, in3}), 32'd3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abt.busy",  32'(busy), 32'd0);
        chk("abt.idx",   32'({in1, in2, in3}), 32'd0);
        chk("abt.done",  32'(done), 32'd0);
        chk("abt.match", 32'(match), 32'd0);
        chk("abt.mm",    32'(mismatch), 32'd0);
        chk("abt.res",   32'(result), 32'h80);
        saw_done = 1'b0;
        for (int j = 0; j < 50; j++) begin
            if (done || busy) saw_done = 1'b1;
            @(negedge clk);
        end
        chk("abt.quiet", 32'(saw_done), 32'd0);
        sweep4(8'h89, 8'h89, 1'b0, 1'b0, "restart");

        // start while busy, start+abort in IDLE, abort during DONE
        sweep4(8'h89, 8'h89, 1'b1, 1'b0, "midstart");
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("sa.busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("sa.idx", 32'({in1, in2, in3}), 32'd0);
        sweep4(8'h89, 8'h89, 1'b0, 1'b1, "abtdone");

        // Random gates and expected codes
        for (int i = 0; i < 4; i++) begin
            g = 8'($urandom);
            e = (i % 2 == 1) ? g : 8'($urandom);
            gate_code = g;
            sweep4(e, g, 1'b0, 1'b0, "rnd");
        end

        // Asynchronous reset at row 5, then a clean sweep
        gate_code = 8'h89;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (27) @(negedge clk);
        chk("ar.row5", 32'({in1, in2, in3}), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar.idx",  32'({in1, in2, in3}), 32'd0);
        chk("ar.busy", 32'(busy), 32'd0);
        chk("ar.res",  32'(result), 32'd0);
        chk("ar.mm",   32'(mismatch), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        sweep4(8'h89, 8'h89, 1'b0, 1'b0, "postrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
